// File: rtl/tawas_thread_sched.sv
// Round-robin thread scheduler for the 32-thread Tawas barrel pipeline.
// Issues at most one enabled, non-busy thread per cycle and tracks start/stop/retire/halt.
module tawas_thread_sched #(
   parameter int                 NTHREAD     = 32,
   parameter int                 TW          = 5,
   parameter logic [NTHREAD-1:0] RST_EN_MASK = 32'h0000_0001
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               ctl_start_en,
   input  logic [TW-1:0]      ctl_start_id,
   input  logic               ctl_stop_en,
   input  logic [TW-1:0]      ctl_stop_id,
   input  logic               issue_stall,
   output logic               issue_en,
   output logic [TW-1:0]      issue_sel,
   input  logic               retire_en,
   input  logic [TW-1:0]      retire_sel,
   input  logic               retire_halt,
   output logic [NTHREAD-1:0] thread_enabled,
   output logic [NTHREAD-1:0] thread_busy,
   output logic               halt_event,
   output logic [TW-1:0]      halt_id,
   output logic               sched_err
);

   function automatic logic [NTHREAD-1:0] onehot(input logic [TW-1:0] id);
      onehot = {{(NTHREAD-1){1'b0}}, 1'b1} << id;
   endfunction

   logic [NTHREAD-1:0] enabled_r;
   logic [NTHREAD-1:0] busy_r;
   logic [TW-1:0]      ptr_r;
   logic               issue_en_r;
   logic [TW-1:0]      issue_sel_r;
   logic               halt_event_r;
   logic [TW-1:0]      halt_id_r;
   logic               sched_err_r;

   logic [NTHREAD-1:0] elig_s;
   logic [TW-1:0]      idx_s;
   logic               hit_s;
   logic               found_s;
   logic [TW-1:0]      off_s;
   logic [TW-1:0]      pick_s;
   logic               issue_go_s;
   logic               halt_s;
   logic               retire_bad_s;
   logic [NTHREAD-1:0] en_nxt_s;
   logic [NTHREAD-1:0] busy_nxt_s;

   // Round-robin search: the lowest offset from ptr with an eligible thread wins.
   always_comb begin
      elig_s  = enabled_r & ~busy_r;
      idx_s   = {TW{1'b0}};
      hit_s   = 1'b0;
      found_s = 1'b0;
      off_s   = {TW{1'b0}};
      for (int i = NTHREAD - 1; i >= 0; i--) begin
         idx_s   = ptr_r + TW'(i);
         hit_s   = elig_s[idx_s];
         found_s = found_s | hit_s;
         off_s   = hit_s ? TW'(i) : off_s;
      end
      pick_s     = ptr_r + off_s;
      issue_go_s = found_s & ~issue_stall;
   end

   // Next enabled/busy vectors; mask order gives stop > start > halt for one thread.
   always_comb begin
      halt_s       = retire_en & retire_halt;
      retire_bad_s = retire_en & ~busy_r[retire_sel];
      en_nxt_s     = enabled_r & ~({NTHREAD{halt_s}} & onehot(retire_sel));
      en_nxt_s     = en_nxt_s | ({NTHREAD{ctl_start_en}} & onehot(ctl_start_id));
      en_nxt_s     = en_nxt_s & ~({NTHREAD{ctl_stop_en}} & onehot(ctl_stop_id));
      busy_nxt_s   = busy_r & ~({NTHREAD{retire_en}} & onehot(retire_sel));
      busy_nxt_s   = busy_nxt_s | ({NTHREAD{issue_go_s}} & onehot(pick_s));
   end

   // Scheduler state and registered outputs.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         enabled_r    <= RST_EN_MASK;
         busy_r       <= {NTHREAD{1'b0}};
         ptr_r        <= {TW{1'b0}};
         issue_en_r   <= 1'b0;
         issue_sel_r  <= {TW{1'b0}};
         halt_event_r <= 1'b0;
         halt_id_r    <= {TW{1'b0}};
         sched_err_r  <= 1'b0;
      end else begin
         enabled_r    <= en_nxt_s;
         busy_r       <= busy_nxt_s;
         ptr_r        <= issue_go_s ? pick_s + TW'(1) : ptr_r;
         issue_en_r   <= issue_go_s;
         issue_sel_r  <= issue_go_s ? pick_s : issue_sel_r;
         halt_event_r <= halt_s;
         halt_id_r    <= halt_s ? retire_sel : halt_id_r;
         sched_err_r  <= sched_err_r | retire_bad_s;
      end
   end

   assign thread_enabled = enabled_r;
   assign thread_busy    = busy_r;
   assign issue_en       = issue_en_r;
   assign issue_sel      = issue_sel_r;
   assign halt_event     = halt_event_r;
   assign halt_id        = halt_id_r;
   assign sched_err      = sched_err_r;

endmodule

// File: tb/tb_tawas_thread_sched.sv
// Directed self-checking bench for tawas_thread_sched.
module tb_tawas_thread_sched;

   logic        clk;
   logic        rst_n;
   logic        ctl_start_en;
   logic [4:0]  ctl_start_id;
   logic        ctl_stop_en;
   logic [4:0]  ctl_stop_id;
   logic        issue_stall;
   logic        issue_en;
   logic [4:0]  issue_sel;
   logic        retire_en;
   logic [4:0]  retire_sel;
   logic        retire_halt;
   logic [31:0] thread_enabled;
   logic [31:0] thread_busy;
   logic        halt_event;
   logic [4:0]  halt_id;
   logic        sched_err;

   int checks;
   int errors;

   tawas_thread_sched dut (
      .clk            (clk),
      .rst_n          (rst_n),
      .ctl_start_en   (ctl_start_en),
      .ctl_start_id   (ctl_start_id),
      .ctl_stop_en    (ctl_stop_en),
      .ctl_stop_id    (ctl_stop_id),
      .issue_stall    (issue_stall),
      .issue_en       (issue_en),
      .issue_sel      (issue_sel),
      .retire_en      (retire_en),
      .retire_sel     (retire_sel),
      .retire_halt    (retire_halt),
      .thread_enabled (thread_enabled),
      .thread_busy    (thread_busy),
      .halt_event     (halt_event),
      .halt_id        (halt_id),
      .sched_err      (sched_err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_inputs();
      ctl_start_en = 1'b0; ctl_start_id = 5'd0;
      ctl_stop_en  = 1'b0; ctl_stop_id  = 5'd0;
      retire_en    = 1'b0; retire_sel   = 5'd0; retire_halt = 1'b0;
   endtask

   task automatic do_reset(input logic stall);
      idle_inputs();
      issue_stall = stall;
      rst_n = 1'b0;
      #2;
      rst_n = 1'b1;
   endtask

   task automatic start_cmd(input logic [4:0] id);
      ctl_start_en = 1'b1; ctl_start_id = id;
      tick();
      ctl_start_en = 1'b0;
   endtask

   task automatic test_reset();
      idle_inputs();
      issue_stall = 1'b0;
      rst_n = 1'b0;
      #12;
      checks++; if (issue_en !== 1'b0) begin errors++; $display("FAIL rst_issue_en got %0h want 0", issue_en); end
      checks++; if (thread_enabled !== 32'h0000_0001) begin errors++; $display("FAIL rst_enabled got %h want 00000001", thread_enabled); end
      checks++; if (thread_busy !== 32'h0) begin errors++; $display("FAIL rst_busy got %h want 0", thread_busy); end
      checks++; if ({halt_event, halt_id, sched_err, issue_sel} !== 12'h0) begin errors++; $display("FAIL rst_misc got %h want 0", {halt_event, halt_id, sched_err, issue_sel}); end
      rst_n = 1'b1;
      tick();
      checks++; if ({issue_en, issue_sel} !== {1'b1, 5'd0}) begin errors++; $display("FAIL t1_first_issue got %b/%0d want 1/0", issue_en, issue_sel); end
      checks++; if (thread_busy !== 32'h1) begin errors++; $display("FAIL t1_busy got %h want 00000001", thread_busy); end
      for (int i = 0; i < 3; i++) begin
         tick();
         checks++; if (issue_en !== 1'b0) begin errors++; $display("FAIL t1_busy_noissue cyc %0d got %b want 0", i, issue_en); end
      end
      retire_en = 1'b1; retire_sel = 5'd0;
      tick();
      retire_en = 1'b0;
      checks++; if ({issue_en, thread_busy} !== 33'h0) begin errors++; $display("FAIL t1_retire_edge got %b/%h want 0/0", issue_en, thread_busy); end
      tick();
      checks++; if ({issue_en, issue_sel} !== {1'b1, 5'd0}) begin errors++; $display("FAIL t1_reissue got %b/%0d want 1/0", issue_en, issue_sel); end
   endtask

   task automatic test_round_robin();
      int exp_id;
      int r;
      do_reset(1'b1);
      start_cmd(5'd1);
      start_cmd(5'd2);
      start_cmd(5'd3);
      issue_stall = 1'b0;
      for (int k = 1; k <= 15; k++) begin
         r = k - 4;
         if (r >= 1 && (r % 5) != 0) begin
            retire_en = 1'b1; retire_sel = 5'((r % 5) - 1);
         end else begin
            retire_en = 1'b0;
         end
         tick();
         retire_en = 1'b0;
         exp_id = (k % 5) - 1;
         if (exp_id < 0) begin
            checks++; if (issue_en !== 1'b0) begin errors++; $display("FAIL t2_gap k=%0d got %b want 0", k, issue_en); end
         end else begin
            checks++; if ({issue_en, issue_sel} !== {1'b1, 5'(exp_id)}) begin errors++; $display("FAIL t2_order k=%0d got %b/%0d want 1/%0d", k, issue_en, issue_sel, exp_id); end
         end
      end
      checks++; if (sched_err !== 1'b0) begin errors++; $display("FAIL t2_err got %b want 0", sched_err); end
   endtask

   task automatic test_wrap();
      do_reset(1'b1);
      ctl_stop_en = 1'b1; ctl_stop_id = 5'd0;
      ctl_start_en = 1'b1; ctl_start_id = 5'd30;
      tick();
      idle_inputs();
      issue_stall = 1'b0;
      tick();
      issue_stall = 1'b1;
      checks++; if ({issue_en, issue_sel} !== {1'b1, 5'd30}) begin errors++; $display("FAIL t3_seed got %b/%0d want 1/30", issue_en, issue_sel); end
      retire_en = 1'b1; retire_sel = 5'd30;
      ctl_start_en = 1'b1; ctl_start_id = 5'd31;
      tick();
      retire_en = 1'b0;
      checks++; if (issue_en !== 1'b0) begin errors++; $display("FAIL t3_stalled got %b want 0", issue_en); end
      start_cmd(5'd1);
      issue_stall = 1'b0;
      tick();
      checks++; if ({issue_en, issue_sel} !== {1'b1, 5'd31}) begin errors++; $display("FAIL t3_first got %b/%0d want 1/31", issue_en, issue_sel); end
      checks++; if (dut.ptr_r !== 5'd0) begin errors++; $display("FAIL t3_ptr_wrap got %0d want 0", dut.ptr_r); end
      tick();
      checks++; if ({issue_en, issue_sel} !== {1'b1, 5'd1}) begin errors++; $display("FAIL t3_second got %b/%0d want 1/1", issue_en, issue_sel); end
      tick();
      checks++; if ({issue_en, issue_sel} !== {1'b1, 5'd30}) begin errors++; $display("FAIL t3_third got %b/%0d want 1/30", issue_en, issue_sel); end
      tick();
      checks++; if ({issue_en, issue_sel} !== {1'b0, 5'd30}) begin errors++; $display("FAIL t3_hold_sel got %b/%0d want 0/30", issue_en, issue_sel); end
   endtask

   task automatic test_halt();
      do_reset(1'b1);
      ctl_stop_en = 1'b1; ctl_stop_id = 5'd0;
      ctl_start_en = 1'b1; ctl_start_id = 5'd5;
      tick();
      idle_inputs();
      issue_stall = 1'b0;
      tick();
      checks++; if ({issue_en, issue_sel} !== {1'b1, 5'd5}) begin errors++; $display("FAIL t4_issue got %b/%0d want 1/5", issue_en, issue_sel); end
      tick();
      retire_en = 1'b1; retire_sel = 5'd5; retire_halt = 1'b1;
      tick();
      idle_inputs();
      checks++; if ({halt_event, halt_id} !== {1'b1, 5'd5}) begin errors++; $display("FAIL t4_halt got %b/%0d want 1/5", halt_event, halt_id); end
      checks++; if ({thread_enabled[5], thread_busy[5], sched_err} !== 3'b000) begin errors++; $display("FAIL t4_state got %b want 000", {thread_enabled[5], thread_busy[5], sched_err}); end
      tick();
      checks++; if (halt_event !== 1'b0) begin errors++; $display("FAIL t4_pulse got %b want 0", halt_event); end
      for (int i = 0; i < 4; i++) begin
         tick();
         checks++; if (issue_en !== 1'b0) begin errors++; $display("FAIL t4_no_reissue cyc %0d got %b want 0", i, issue_en); end
      end
      start_cmd(5'd5);
      checks++; if (issue_en !== 1'b0) begin errors++; $display("FAIL t4_start_lat got %b want 0", issue_en); end
      tick();
      checks++; if ({issue_en, issue_sel} !== {1'b1, 5'd5}) begin errors++; $display("FAIL t4_restart got %b/%0d want 1/5", issue_en, issue_sel); end
   endtask

   task automatic test_precedence();
      do_reset(1'b1);
      ctl_stop_en = 1'b1; ctl_stop_id = 5'd0;
      ctl_start_en = 1'b1; ctl_start_id = 5'd7;
      tick();
      idle_inputs();
      issue_stall = 1'b0;
      tick();
      issue_stall = 1'b1;
      checks++; if ({issue_en, issue_sel} !== {1'b1, 5'd7}) begin errors++; $display("FAIL t5_issue_a got %b/%0d want 1/7", issue_en, issue_sel); end
      ctl_stop_en = 1'b1; ctl_stop_id = 5'd7;
      ctl_start_en = 1'b1; ctl_start_id = 5'd7;
      retire_en = 1'b1; retire_sel = 5'd7; retire_halt = 1'b1;
      tick();
      idle_inputs();
      checks++; if ({thread_enabled[7], halt_event} !== 2'b01) begin errors++; $display("FAIL t5_stop_wins got %b want 01", {thread_enabled[7], halt_event}); end
      start_cmd(5'd7);
      issue_stall = 1'b0;
      tick();
      issue_stall = 1'b1;
      checks++; if ({issue_en, issue_sel} !== {1'b1, 5'd7}) begin errors++; $display("FAIL t5_issue_b got %b/%0d want 1/7", issue_en, issue_sel); end
      ctl_start_en = 1'b1; ctl_start_id = 5'd7;
      retire_en = 1'b1; retire_sel = 5'd7; retire_halt = 1'b1;
      tick();
      idle_inputs();
      checks++; if ({thread_enabled[7], thread_busy[7], halt_event, halt_id} !== {3'b101, 5'd7}) begin errors++; $display("FAIL t5_start_wins got %b want 10100111", {thread_enabled[7], thread_busy[7], halt_event, halt_id}); end
   endtask

   task automatic test_stall_err();
      do_reset(1'b1);
      ctl_stop_en = 1'b1; ctl_stop_id = 5'd0;
      ctl_start_en = 1'b1; ctl_start_id = 5'd2;
      tick();
      idle_inputs();
      start_cmd(5'd4);
      for (int i = 0; i < 3; i++) begin
         tick();
         checks++; if ({issue_en, dut.ptr_r} !== 6'd0) begin errors++; $display("FAIL t6_stall cyc %0d got %b/%0d want 0/0", i, issue_en, dut.ptr_r); end
      end
      issue_stall = 1'b0;
      tick();
      checks++; if ({issue_en, issue_sel} !== {1'b1, 5'd2}) begin errors++; $display("FAIL t6_first got %b/%0d want 1/2", issue_en, issue_sel); end
      tick();
      checks++; if ({issue_en, issue_sel} !== {1'b1, 5'd4}) begin errors++; $display("FAIL t6_second got %b/%0d want 1/4", issue_en, issue_sel); end
      retire_en = 1'b1; retire_sel = 5'd9;
      tick();
      retire_en = 1'b0;
      checks++; if ({sched_err, thread_busy} !== {1'b1, 32'h0000_0014}) begin errors++; $display("FAIL t6_err got %b/%h want 1/00000014", sched_err, thread_busy); end
      tick(); tick();
      checks++; if (sched_err !== 1'b1) begin errors++; $display("FAIL t6_sticky got %b want 1", sched_err); end
      #2;
      rst_n = 1'b0;
      #1;
      checks++; if ({sched_err, issue_en, thread_busy, thread_enabled} !== {2'b00, 32'h0, 32'h1}) begin errors++; $display("FAIL t6_async_rst got %b/%b/%h/%h want 0/0/0/1", sched_err, issue_en, thread_busy, thread_enabled); end
      rst_n = 1'b1;
   endtask

   initial begin
      checks = 0;
      errors = 0;
      test_reset();
      test_round_robin();
      test_wrap();
      test_halt();
      test_precedence();
      test_stall_err();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/tawas_thread_sched.md
Name: tawas_thread_sched

Overview:
Round-robin thread scheduler for the 32-thread Tawas barrel pipeline.
- Tracks per-thread enabled/busy state.
- Issues at most one eligible thread per cycle to instruction fetch.
- Accepts start/stop commands from the control bus.
- Consumes retire/halt feedback from the pipeline tail.
- Replaces fixed-priority thread picking so that no thread starves.

Parameters:
NTHREAD, 32, number of hardware threads (power of two).
TW, 5, thread-id width, log2(NTHREAD).
RST_EN_MASK, 32'h0000_0001, value loaded into the enabled vector at reset (thread 0 runs).

Ports:
clk  input  1  clock; all state updates on the rising edge.
rst_n  input  1  reset, asynchronous, active-low.
ctl_start_en  input  1  start command valid.
ctl_start_id  input  TW  thread to enable.
ctl_stop_en  input  1  stop command valid.
ctl_stop_id  input  TW  thread to disable.
issue_stall  input  1  fetch cannot accept an issue this cycle.
issue_en  output  1  registered; thread issued to fetch this cycle.
issue_sel  output  TW  registered; issued thread id.
retire_en  input  1  thread leaving the pipeline.
retire_sel  input  TW  retiring thread id.
retire_halt  input  1  retiring thread executed halt.
thread_enabled  output  NTHREAD  enabled vector.
thread_busy  output  NTHREAD  in-pipeline vector.
halt_event  output  1  one-cycle pulse, a thread halted.
halt_id  output  TW  id of the halted thread, valid with halt_event.
sched_err  output  1  sticky: retire seen for a non-busy thread.

Behaviour:
Reset (rst_n low, asynchronous):
- thread_enabled = RST_EN_MASK; thread_busy = 0.
- issue_en = 0, issue_sel = 0; round-robin pointer ptr = 0.
- halt_event = 0, halt_id = 0, sched_err = 0.
- Reset asserted mid-operation discards all in-flight state; nothing is retained.

Eligibility (combinational): elig = thread_enabled & ~thread_busy, using current register values.

Selection:
- Find the first set bit of elig searching ptr, ptr+1, ..., wrapping modulo NTHREAD.
- If a bit is found and issue_stall = 0, at the next edge:
  - issue_en <= 1, issue_sel <= id;
  - thread_busy[id] <= 1;
  - ptr <= id+1 (mod NTHREAD).
- Otherwise issue_en <= 0; issue_sel holds its previous value; ptr is unchanged.
- Latency: a thread eligible in cycle N appears on issue_en/issue_sel in cycle N+1.

Retire:
- retire_en with thread_busy[retire_sel] = 1: busy bit cleared at the edge. The thread is eligible the following cycle, so issue_en asserts no earlier than 2 cycles after the retire.
- retire_en with thread_busy[retire_sel] = 0: busy is unchanged and sched_err <= 1 (sticky until reset).
- Retire and issue of different threads in the same cycle both take effect.
- A thread cannot be issued and retired in the same cycle, because issue requires busy = 0.

Halt:
- retire_en & retire_halt: thread_enabled[retire_sel] <= 0 and busy cleared.
- halt_event <= 1 and halt_id <= retire_sel, as a one-cycle pulse.

Enable precedence per thread, same cycle: stop > start > halt.
- Stop clears enabled immediately. A busy thread completes its in-flight instruction and is not reissued.
- Start on a halting thread leaves it enabled; halt_event still pulses.
- Start on an already-enabled thread has no effect.
- Stop, then start, before retire: the thread is reissued after its retire.

Arithmetic: ptr is TW bits wide and wraps naturally, so 31+1 = 0.

Outputs: thread_enabled and thread_busy are direct register outputs.

Test Plan:
1. Reset with default mask, no stall -> cycle 1: issue_en=1, issue_sel=0, thread_busy=32'h1. While busy: issue_en=0. Retire 0 -> issue_en=1, issue_sel=0 exactly 2 cycles after retire_en.
2. Start threads 0..3, retire each 4 cycles after its issue -> issue order 0,1,2,3,0,1,... No thread is issued twice before all others.
3. Start threads 30, 31 and 1; ptr=31 -> issue order 31,1,30 (wrap-around). Verify ptr returns to 0 after thread 31 is issued.
4. Thread 5 busy, retire_en=1, retire_sel=5, retire_halt=1 -> next cycle: halt_event=1, halt_id=5, thread_enabled[5]=0. Thread 5 is never reissued until ctl_start_id=5.
5. Same cycle: ctl_stop_id=7, ctl_start_id=7, retire_halt on 7 -> thread_enabled[7]=0. Same cycle: ctl_start=7 with halt on 7 -> thread_enabled[7]=1, halt_event=1.
6. issue_stall held 3 cycles with threads 2 and 4 eligible -> issue_en=0 and ptr unchanged during the stall, then 2 is issued first. A retire of idle thread 9 -> sched_err=1, held until rst_n low.
